test_port_reporter: RTL and testbench

//  Bus-master end of the test-port result protocol. On start, writes BEGIN_SYM to word address

---
 rtl/test_port_reporter.sv | 232 +++++++++++++++++++++++
 tb/tb_test_port_reporter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/test_port_reporter.sv
`default_nettype none
// ============================================================================
// Module      : test_port_reporter
// Description : Bus-master end of the test-port result protocol. On start it
//               writes BEGIN_SYM to TEST_PORT, then NUM_WORDS result words
//               fetched from a 1-cycle-latency source memory, then END_SYM.
//               Every write is held bit-stable while stall=1, and wen drops
//               for at least one cycle after every accepted write.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1       clock, rising edge
//   rst        in   1       synchronous active-high reset
//   start      in   1       start pulse, sampled only in IDLE
//   stall      in   1       bus stall, current write not accepted while 1
//   src_ren    out  1       source read enable
//   src_addr   out  SRC_AW  source word index
//   src_rdata  in   32      source data, valid the cycle after src_ren
//   addr       out  30      bus word address (TEST_PORT while wen, else 0)
//   data       out  32      bus write data (registered)
//   wen        out  1       bus write enable
//   busy       out  1       sequence in progress
//   done       out  1       sticky completion flag (cleared by rst)
//   cycles     out  16      cycles from start to done, saturating
// Configuration
//   REPORT_CHECKSUM_EN : when defined, a 32-bit wrapping sum of the result
//                        words is written between the last word and END_SYM.
// ============================================================================
module test_port_reporter #(
    parameter logic [29:0] TEST_PORT = 30'h40,
    parameter logic [31:0] BEGIN_SYM = 32'h0000_0932,
    parameter logic [31:0] END_SYM   = 32'h0000_0D5D,
    parameter int          NUM_WORDS = 50,
    parameter int          SRC_AW    = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    output logic              src_ren,
    output logic [SRC_AW-1:0] src_addr,
    input  logic [31:0]       src_rdata,
    output logic [29:0]       addr,
    output logic [31:0]       data,
    output logic              wen,
    output logic              busy,
    output logic              done,
    output logic [15:0]       cycles
);

    // Index of the final result word; only meaningful when NUM_WORDS > 0.
    localparam logic [SRC_AW:0] c_LAST_IDX =
        (NUM_WORDS > 0) ? (SRC_AW+1)'(NUM_WORDS - 1) : '0;
    localparam bit c_HAS_WORDS = (NUM_WORDS > 0);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_BEG   = 4'd1,
        S_FETCH = 4'd2,
        S_WAIT  = 4'd3,
        S_DATA  = 4'd4,
        S_GAP   = 4'd5,
        S_END   = 4'd6,
        S_DONE  = 4'd7
`ifdef REPORT_CHECKSUM_EN
        ,
        S_CSUM  = 4'd8,
        S_GAP2  = 4'd9
`endif
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_wen;
    logic              w_src_ren;
    logic [31:0]       r_data;
    logic [SRC_AW:0]   r_index;    // one extra bit so 2**SRC_AW words fit
    logic [15:0]       r_cycles;
`ifdef REPORT_CHECKSUM_EN
    logic [31:0]       r_sum;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_wen       = 1'b0;
        w_src_ren   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_BEG;
                end
            end
            S_BEG: begin
                w_wen = 1'b1;
                if (!stall) begin
                    w_state_nxt = c_HAS_WORDS ? S_FETCH : S_GAP;
                end
            end
            S_FETCH: begin
                w_src_ren   = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_state_nxt = S_DATA;
            end
            S_DATA: begin
                w_wen = 1'b1;
                if (!stall) begin
                    w_state_nxt = (r_index == c_LAST_IDX) ? S_GAP : S_FETCH;
                end
            end
            S_GAP: begin
`ifdef REPORT_CHECKSUM_EN
                w_state_nxt = S_CSUM;
`else
                w_state_nxt = S_END;
`endif
            end
`ifdef REPORT_CHECKSUM_EN
            S_CSUM: begin
                w_wen = 1'b1;
                if (!stall) begin
                    w_state_nxt = S_GAP2;
                end
            end
            S_GAP2: begin
                w_state_nxt = S_END;
            end
`endif
            S_END: begin
                w_wen = 1'b1;
                if (!stall) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_DONE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: write data, source index, checksum, cycle counter.
    // r_data only changes in non-write states, so it is naturally stable
    // for as long as a write is stalled.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data   <= '0;
            r_index  <= '0;
            r_cycles <= '0;
`ifdef REPORT_CHECKSUM_EN
            r_sum    <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_data   <= BEGIN_SYM;
                        r_index  <= '0;
                        r_cycles <= '0;
`ifdef REPORT_CHECKSUM_EN
                        r_sum    <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    r_data <= src_rdata;
                end
                S_DATA: begin
                    if (!stall) begin
`ifdef REPORT_CHECKSUM_EN
                        r_sum <= r_sum + r_data;
`endif
                        if (r_index != c_LAST_IDX) begin
                            r_index <= r_index + 1'b1;
                        end
                    end
                end
                S_GAP: begin
`ifdef REPORT_CHECKSUM_EN
                    r_data <= r_sum;
`else
                    r_data <= END_SYM;
`endif
                end
`ifdef REPORT_CHECKSUM_EN
                S_GAP2: begin
                    r_data <= END_SYM;
                end
`endif
                default: begin
                end
            endcase

            if (busy && (r_cycles != 16'hFFFF)) begin
                r_cycles <= r_cycles + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wen      = w_wen;
    assign src_ren  = w_src_ren;
    assign src_addr = r_index[SRC_AW-1:0];
    assign addr     = w_wen ? TEST_PORT : 30'd0;
    assign data     = r_data;
    assign busy     = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done     = (r_state == S_DONE);
    assign cycles   = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_test_port_reporter.sv
`default_nettype none
// ============================================================================
// Module      : tb_test_port_reporter
// Description : Self-checking bench for test_port_reporter. Three instances
//               (50 words, 0 words, 4 words filling a 2-bit source space)
//               share clock, reset, start and stall; one is observed per run.
//               Expected bus activity is derived from a write-list model:
//               each write appears a fixed gap after the previous one was
//               accepted and stays up until a cycle with stall=0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_test_port_reporter;

    localparam logic [31:0] c_BEGIN_SYM = 32'h0000_0932;
    localparam logic [31:0] c_END_SYM   = 32'h0000_0D5D;
    localparam logic [29:0] c_TEST_PORT = 30'h40;
    localparam int          c_MAXC      = 1024;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;
    logic stall = 1'b0;

    always #5 clk = ~clk;

    logic [31:0] mem [64];

    // instance a : 50 words
    logic a_ren; logic [5:0] a_raddr; logic [31:0] a_rdata; logic [29:0] a_addr;
    logic [31:0] a_data; logic a_wen, a_busy, a_done; logic [15:0] a_cyc;
    // instance b : 0 words
    logic b_ren; logic [5:0] b_raddr; logic [31:0] b_rdata; logic [29:0] b_addr;
    logic [31:0] b_data; logic b_wen, b_busy, b_done; logic [15:0] b_cyc;
    // instance c : 4 words, SRC_AW = 2 (full source space)
    logic c_ren; logic [1:0] c_raddr; logic [31:0] c_rdata; logic [29:0] c_addr;
    logic [31:0] c_data; logic c_wen, c_busy, c_done; logic [15:0] c_cyc;

    test_port_reporter #(.NUM_WORDS(50), .SRC_AW(6)) u_a (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .src_ren(a_ren), .src_addr(a_raddr), .src_rdata(a_rdata),
        .addr(a_addr), .data(a_data), .wen(a_wen), .busy(a_busy),
        .done(a_done), .cycles(a_cyc));

    test_port_reporter #(.NUM_WORDS(0), .SRC_AW(6)) u_b (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .src_ren(b_ren), .src_addr(b_raddr), .src_rdata(b_rdata),
        .addr(b_addr), .data(b_data), .wen(b_wen), .busy(b_busy),
        .done(b_done), .cycles(b_cyc));

    test_port_reporter #(.NUM_WORDS(4), .SRC_AW(2)) u_c (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .src_ren(c_ren), .src_addr(c_raddr), .src_rdata(c_rdata),
        .addr(c_addr), .data(c_data), .wen(c_wen), .busy(c_busy),
        .done(c_done), .cycles(c_cyc));

    // 1-cycle-latency source memories
    always @(posedge clk) begin
        if (a_ren) a_rdata <= mem[a_raddr];
        if (b_ren) b_rdata <= mem[b_raddr];
        if (c_ren) c_rdata <= mem[{4'd0, c_raddr}];
    end

    // observed-instance mux
    int          sel = 0;
    logic        m_ren, m_wen, m_busy, m_done;
    logic [5:0]  m_raddr;
    logic [29:0] m_addr;
    logic [31:0] m_data;
    logic [15:0] m_cyc;

    always_comb begin
        m_ren = a_ren; m_raddr = a_raddr; m_addr = a_addr; m_data = a_data;
        m_wen = a_wen; m_busy = a_busy; m_done = a_done; m_cyc = a_cyc;
        if (sel == 1) begin
            m_ren = b_ren; m_raddr = b_raddr; m_addr = b_addr; m_data = b_data;
            m_wen = b_wen; m_busy = b_busy; m_done = b_done; m_cyc = b_cyc;
        end else if (sel == 2) begin
            m_ren = c_ren; m_raddr = {4'd0, c_raddr}; m_addr = c_addr; m_data = c_data;
            m_wen = c_wen; m_busy = c_busy; m_done = c_done; m_cyc = c_cyc;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    bit          stall_pat [c_MAXC];
    logic        e_wen     [c_MAXC];
    logic [31:0] e_dat     [c_MAXC];
    logic        e_ren     [c_MAXC];
    logic [5:0]  e_ra      [c_MAXC];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic fill_mem(input bit seq);
        for (int i = 0; i < 64; i++) mem[i] = seq ? 32'(i + 1) : $urandom;
    endtask

    task automatic fill_stall(input int pct);
        for (int i = 0; i < c_MAXC; i++)
            stall_pat[i] = (i < 500) && ($urandom_range(0, 99) < pct);
    endtask

    // One sequence on instance s. rst_at >= 1 asserts reset in that cycle and
    // ends the run after checking the following cycle.
    task automatic run_seq(input int s, input int rst_at, input bit pulses);
        int          nw;
        int          gap[$];
        logic [31:0] wd[$];
        logic [31:0] sum;
        int          t, c, last;

        sel = s;
        nw  = (s == 0) ? 50 : (s == 1) ? 0 : 4;
        sum = 32'd0;
        wd.push_back(c_BEGIN_SYM); gap.push_back(1);
        for (int i = 0; i < nw; i++) begin
            wd.push_back(mem[i]); gap.push_back(3); sum += mem[i];
        end
`ifdef REPORT_CHECKSUM_EN
        wd.push_back(sum); gap.push_back(2);
`endif
        wd.push_back(c_END_SYM); gap.push_back(2);

        for (int i = 0; i < c_MAXC; i++) begin
            e_wen[i] = 1'b0; e_dat[i] = '0; e_ren[i] = 1'b0; e_ra[i] = '0;
        end
        t = 0;
        foreach (wd[k]) begin
            c = t + gap[k];
            if (k >= 1 && k <= nw) begin
                e_ren[c-2] = 1'b1;
                e_ra[c-2]  = 6'(k - 1);
            end
            while (stall_pat[c]) begin
                e_wen[c] = 1'b1; e_dat[c] = wd[k]; c++;
            end
            e_wen[c] = 1'b1; e_dat[c] = wd[k];
            t = c;
        end
        last = t;

        @(negedge clk);
        start = 1'b1;
        stall = stall_pat[0];
        @(posedge clk);                     // edge 0: start sampled
        for (int cy = 1; cy <= last + 3; cy++) begin
            @(negedge clk);
            if (rst_at > 0 && cy == rst_at + 1) begin
                chk("rst_wen",  m_wen,  1'b0);
                chk("rst_busy", m_busy, 1'b0);
                chk("rst_done", m_done, 1'b0);
                rst = 1'b0; start = 1'b0; stall = 1'b0;
                return;
            end
            stall = stall_pat[cy];
            start = pulses ? ((cy == 5) || (cy == 160) || ($urandom_range(0, 15) == 0)) : 1'b0;
            chk("wen", m_wen, e_wen[cy]);
            if (e_wen[cy]) begin
                chk("addr", m_addr, c_TEST_PORT);
                chk("data", m_data, e_dat[cy]);
            end else begin
                chk("addr_idle", m_addr, 30'd0);
            end
            chk("src_ren", m_ren, e_ren[cy]);
            if (e_ren[cy]) chk("src_addr", m_raddr, e_ra[cy]);
            chk("busy", m_busy, cy <= last);
            chk("done", m_done, cy > last);
            if (cy <= last) chk("cycles", m_cyc, 32'(cy - 1));
            else            chk("cycles_final", m_cyc, 32'(last));
            if (cy == rst_at) rst = 1'b1;
        end
        start = 1'b0;
        stall = 1'b0;
    endtask

    initial begin
        // reset state
        do_reset();
        @(negedge clk);
        sel = 0;
        chk("reset_wen",     a_wen,   1'b0);
        chk("reset_busy",    a_busy,  1'b0);
        chk("reset_done",    a_done,  1'b0);
        chk("reset_addr",    a_addr,  30'd0);
        chk("reset_data",    a_data,  32'd0);
        chk("reset_cycles",  a_cyc,   16'd0);
        chk("reset_src_ren", a_ren,   1'b0);
        chk("reset_src_adr", a_raddr, 6'd0);

        // 50 words, src[i]=i+1, no stall, extra start pulses ignored
        fill_mem(1'b1);
        fill_stall(0);
        run_seq(0, -1, 1'b1);

        // same, with a 4-cycle stall on word 10
        do_reset();
        fill_stall(0);
        for (int i = 34; i < 38; i++) stall_pat[i] = 1'b1;
        run_seq(0, -1, 1'b0);

        // zero words
        do_reset();
        fill_stall(0);
        run_seq(1, -1, 1'b0);

        // full source space, stall coincident with start
        do_reset();
        fill_mem(1'b0);
        fill_stall(0);
        for (int i = 0; i < 4; i++) stall_pat[i] = 1'b1;
        run_seq(2, -1, 1'b1);

        // reset mid-sequence, then a fresh full sequence
        do_reset();
        fill_mem(1'b0);
        fill_stall(20);
        run_seq(0, 20, 1'b1);
        fill_mem(1'b0);
        fill_stall(20);
        run_seq(0, -1, 1'b1);

        // randomized runs across all instances
        for (int r = 0; r < 6; r++) begin
            do_reset();
            fill_mem(1'b0);
            fill_stall(int'($urandom_range(0, 40)));
            run_seq(r % 3, -1, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
